// File: rtl/exp3_cfg_pkg.sv
// Shared configuration for the expand 3x3 kernel buffer: FSM states, field widths,
// bank geometry and the bank-select encoding used by both read and write sides.
package exp3_cfg_pkg;

    localparam int LIMIT_W     = 7;
    localparam int DEPTH_W     = 6;
    localparam int DIM_W       = 7;
    localparam int ROW_W       = 6;
    localparam int OFFS_W      = 6;
    localparam int ADDR_W      = 7;
    localparam int BANK_OFFSET = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BANK = 3'd2,
        ST_READ      = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_DONE      = 3'd5
    } exp3_state_e;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_e;

    function automatic bank_sel_e other_bank(input bank_sel_e b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/exp3_slice_counter.sv
// Nested kernel/row counter: kernel index wraps into the row index; stops at the
// terminal (last kernel of last row) so the final indices stay visible.
module exp3_slice_counter
    import exp3_cfg_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DEPTH_W-1:0] kernel_max_i,
    input  logic [DIM_W-1:0]   row_max_i,
    output logic [DEPTH_W-1:0] kernel_o,
    output logic [ROW_W-1:0]   row_o,
    output logic               term_o
);

    logic [DEPTH_W-1:0] kernel_q, kernel_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               kernel_end_s;
    logic               row_end_s;

    assign kernel_end_s = (kernel_q == kernel_max_i);
    assign row_end_s    = ({1'b0, row_q} == row_max_i);
    assign term_o       = kernel_end_s && row_end_s;
    assign kernel_o     = kernel_q;
    assign row_o        = row_q;

    // Next-count selection: clear wins, then advance unless already terminal.
    always_comb begin
        kernel_d = kernel_q;
        row_d    = row_q;
        if (clr_i) begin
            kernel_d = '0;
            row_d    = '0;
        end else if (en_i && !term_o) begin
            if (kernel_end_s) begin
                kernel_d = '0;
                row_d    = row_q + 6'd1;
            end else begin
                kernel_d = kernel_q + 6'd1;
            end
        end else begin
            kernel_d = kernel_q;
            row_d    = row_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            kernel_q <= '0;
            row_q    <= '0;
        end else begin
            kernel_q <= kernel_d;
            row_q    <= row_d;
        end
    end

endmodule

// File: rtl/read_config_exp_3x3.sv
// Read-side address generator for the ping-pong expand 3x3 kernel RAM: streams each
// full bank, releases it to the writer, and flags the end of the layer.
module read_config_exp_3x3
    import exp3_cfg_pkg::*;
#(
    parameter int BANK_OFFSET = exp3_cfg_pkg::BANK_OFFSET,
    parameter int ADDR_W      = exp3_cfg_pkg::ADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [LIMIT_W-1:0] one_exp3_ker_addr_limit_i,
    input  logic [DEPTH_W-1:0] exp3_ker_depth_i,
    input  logic [DIM_W-1:0]   layer_dimension_i,
    input  logic [1:0]         bank_full_i,
    input  logic               rd_stall_i,
    output logic               rd_en_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    output logic               rd_valid_o,
    output logic               rd_last_o,
    output logic               chk_nxt_addr_limt_o,
    output logic               rd_bank_o,
    output logic [DEPTH_W-1:0] kernal_count_o,
    output logic [ROW_W-1:0]   row_count_o,
    output logic               fire_end_flag_o,
    output logic               busy_o
);

    exp3_state_e        state_q, state_d;
    bank_sel_e          bank_q, bank_d;
    logic [OFFS_W-1:0]  offset_q, offset_d;
    logic [OFFS_W-1:0]  addr_space_q, addr_space_d;
    logic [DEPTH_W-1:0] kernal_no_q, kernal_no_d;
    logic [DIM_W-1:0]   layer_dim_q, layer_dim_d;
    logic               fire_q, fire_d;
    logic               valid_q, last_q, chk_q, busy_q;
    logic               rd_en_s, last_issue_s, cnt_en_s, cnt_clr_s, term_s;
    logic [LIMIT_W-1:0] lim_sat_s;

    assign lim_sat_s = (one_exp3_ker_addr_limit_i == 7'd0) ? 7'd1 : one_exp3_ker_addr_limit_i;

    exp3_slice_counter u_cnt (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clr_i        (cnt_clr_s),
        .en_i         (cnt_en_s),
        .kernel_max_i (kernal_no_q),
        .row_max_i    (layer_dim_q),
        .kernel_o     (kernal_count_o),
        .row_o        (row_count_o),
        .term_o       (term_s)
    );

    // Next-state, read issue and counter control; start_i overrides everything.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        offset_d     = offset_q;
        addr_space_d = addr_space_q;
        kernal_no_d  = kernal_no_q;
        layer_dim_d  = layer_dim_q;
        fire_d       = fire_q;
        rd_en_s      = 1'b0;
        last_issue_s = 1'b0;
        cnt_en_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        if (start_i) begin
            state_d   = ST_LOAD;
            bank_d    = BANK_0;
            offset_d  = '0;
            fire_d    = 1'b0;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: begin
                    addr_space_d = OFFS_W'(lim_sat_s - 7'd1);
                    kernal_no_d  = exp3_ker_depth_i;
                    layer_dim_d  = layer_dimension_i;
                    state_d      = ST_WAIT_BANK;
                end
                ST_WAIT_BANK: begin
                    if (bank_full_i[bank_q]) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WAIT_BANK;
                    end
                end
                ST_READ: begin
                    if (!rd_stall_i) begin
                        rd_en_s = 1'b1;
                        if (offset_q == addr_space_q) begin
                            // Terminal is known before the release, so the flag can
                            // rise together with the final release pulse.
                            last_issue_s = 1'b1;
                            offset_d     = '0;
                            fire_d       = term_s;
                            state_d      = ST_RELEASE;
                        end else begin
                            offset_d = offset_q + 6'd1;
                        end
                    end else begin
                        offset_d = offset_q;
                    end
                end
                ST_RELEASE: begin
                    bank_d   = other_bank(bank_q);
                    cnt_en_s = 1'b1;
                    if (fire_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_BANK;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, configuration and registered output flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            bank_q       <= BANK_0;
            offset_q     <= '0;
            addr_space_q <= '0;
            kernal_no_q  <= '0;
            layer_dim_q  <= '0;
            fire_q       <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            chk_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            offset_q     <= offset_d;
            addr_space_q <= addr_space_d;
            kernal_no_q  <= kernal_no_d;
            layer_dim_q  <= layer_dim_d;
            fire_q       <= fire_d;
            valid_q      <= rd_en_s;
            last_q       <= last_issue_s;
            chk_q        <= (state_d == ST_RELEASE);
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
        end
    end

    assign rd_en_o             = rd_en_s;
    assign rd_addr_o           = ((bank_q == BANK_1) ? ADDR_W'(BANK_OFFSET) : '0) + ADDR_W'(offset_q);
    assign rd_valid_o          = valid_q;
    assign rd_last_o           = last_q;
    assign chk_nxt_addr_limt_o = chk_q;
    assign rd_bank_o           = bank_q;
    assign fire_end_flag_o     = fire_q;
    assign busy_o              = busy_q;

endmodule
